aui_gearbox_257: RTL

//  Rate-adapting gearbox directly downstream of the 257b block scrambler.
//  - Accepts 257-bit scrambled blocks on a valid/ready interface.
//  - Re-packs them, with no gaps, into OUT_W-bit words for the PMA-side serializer.
//  - Transmission order is bit 0 first, both in and out: input bit 0 is the first scrambled bit.

---
 rtl/aui_gearbox_257_pkg.sv | 13 +
 rtl/aui_gearbox_257_if.sv | 25 ++
 rtl/aui_gearbox_257_bit_shifter.sv | 18 +
 rtl/aui_gearbox_257.sv | 73 +++++++
 4 files changed

// File: rtl/aui_gearbox_257_pkg.sv
// Shared definitions for the 257b AUI transmit path (scrambler and gearbox).
package aui_pkg;

  localparam int BLK_W = 257;

  typedef logic [BLK_W-1:0] blk_t;

  // Bit-buffer fill counter width for a given output word width.
  function automatic int fill_w(input int outW);
    return $clog2(BLK_W + 2 * outW + 1);
  endfunction

endpackage

// File: rtl/aui_gearbox_257_if.sv
// Block-in / word-out handshake bundle between scrambler, gearbox and serializer.
interface aui_gearbox_257_if
  import aui_pkg::*;
#(
  parameter int OUT_W = 128
);

  blk_t             in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/aui_gearbox_257_bit_shifter.sv
// Places one 257-bit block into the gearbox bit buffer at a given bit offset.
module aui_bit_shifter
  import aui_pkg::*;
#(
  parameter int BUF_W = BLK_W + 256,
  parameter int OFF_W = 10
) (
  input  blk_t             i_data,
  input  logic [OFF_W-1:0] i_offset,
  output logic [BUF_W-1:0] o_field
);

  logic [BUF_W-1:0] w_ext;

  assign w_ext   = {{(BUF_W - BLK_W){1'b0}}, i_data};
  assign o_field = w_ext << i_offset;

endmodule

// File: rtl/aui_gearbox_257.sv
// Gapless repacking of 257-bit scrambled blocks into OUT_W-bit serializer words,
// bit 0 first on both sides, with a sticky flag for blocks offered while full.
module aui_gearbox_257
  import aui_pkg::*;
#(
  parameter  int OUT_W  = 128,
  localparam int BUF_W  = BLK_W + 2 * OUT_W,
  localparam int FILL_W = fill_w(OUT_W)
) (
  input  logic              clk,
  input  logic              rst,
  aui_gearbox_257_if.slave  bus,
  input  logic              clr_err,
  output logic              drop_err,
  output logic [FILL_W-1:0] fill
);

  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;
  logic              r_dropErr;

  logic              w_push;
  logic              w_pop;
  logic [FILL_W-1:0] w_fillAfterPop;
  logic [BUF_W-1:0]  w_shifted;
  logic [BUF_W-1:0]  w_field;

  // Handshakes look only at registered fill, so out_ready never reaches in_ready.
  assign bus.in_ready  = (r_fill <= FILL_W'(2 * OUT_W));
  assign bus.out_valid = (r_fill >= FILL_W'(OUT_W));
  assign bus.out_data  = r_buf[OUT_W-1:0];

  assign w_push         = bus.in_valid & bus.in_ready;
  assign w_pop          = bus.out_valid & bus.out_ready;
  assign w_fillAfterPop = w_pop ? (r_fill - FILL_W'(OUT_W)) : r_fill;
  assign w_shifted      = w_pop ? (r_buf >> OUT_W) : r_buf;

  aui_bit_shifter #(
    .BUF_W (BUF_W),
    .OFF_W (FILL_W)
  ) u_shifter (
    .i_data   (bus.in_data),
    .i_offset (w_fillAfterPop),
    .o_field  (w_field)
  );

  // Bits above fill are always zero, so the new block can simply be OR-ed in
  // after the pop shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else begin
      r_buf  <= w_push ? (w_shifted | w_field) : w_shifted;
      r_fill <= w_fillAfterPop + (w_push ? FILL_W'(BLK_W) : FILL_W'(0));
    end
  end

  // A new drop takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dropErr <= 1'b0;
    end else if (bus.in_valid & ~bus.in_ready) begin
      r_dropErr <= 1'b1;
    end else if (clr_err) begin
      r_dropErr <= 1'b0;
    end
  end

  assign drop_err = r_dropErr;
  assign fill     = r_fill;

endmodule
